// File: rtl/is_uart_pkg.sv
// Shared constants for the UART input conditioner: synchroniser depth floor,
// line idle level and the filter counter width helper.
package is_uart_pkg;

  localparam int   IS_SYNC_MIN_STAGES = 2;
  localparam logic IS_UART_IDLE       = 1'b1;

  // Counter must hold 0..FILT_LEN-1; one bit minimum keeps FILT_LEN=1 legal.
  function automatic int is_cnt_width(input int filt_len);
    int w;
    w = $clog2(filt_len + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/is_uart_sync_ch.sv
// One channel: metastability chain, consecutive-sample glitch filter and
// optional edge strobes (built only when IS_UART_SYNC_EDGE_DET_EN is defined).
module is_uart_sync_ch
  import is_uart_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter logic RST_VAL     = IS_UART_IDLE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = is_cnt_width(FILT_LEN);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   s_s;

  // Shift chain; only the last stage is allowed to reach the filter.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
    s_s    = sync_q[SYNC_STAGES-1];
  end

  // Output only follows s after FILT_LEN consecutive disagreeing samples.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (s_s == out_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      out_d = s_s;
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Sync chain, filter counter and filtered level.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= CNT_ZERO;
      out_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign out_o = out_q;

`ifdef IS_UART_SYNC_EDGE_DET_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Strobes derive from the registered level change, so they land with it.
  always_comb begin
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  // Reset clears strobes; a reset-forced level change never raises one.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/is_uart_sync_filt.sv
// Multi-channel synchroniser + glitch filter for asynchronous serial pads.
// Edge strobes exist only when IS_UART_SYNC_EDGE_DET_EN is defined.
module is_uart_sync_filt
  import is_uart_pkg::*;
#(
  parameter int   CH_NUM      = 1,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter logic RST_VAL     = IS_UART_IDLE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CH_NUM-1:0] in_i,
  output logic [CH_NUM-1:0] out_o,
  output logic [CH_NUM-1:0] rise_o,
  output logic [CH_NUM-1:0] fall_o
);

  if (SYNC_STAGES < IS_SYNC_MIN_STAGES) begin : g_bad_sync
    $error("is_uart_sync_filt: SYNC_STAGES=%0d below minimum %0d",
           SYNC_STAGES, IS_SYNC_MIN_STAGES);
  end

  if (FILT_LEN < 1) begin : g_bad_filt
    $error("is_uart_sync_filt: FILT_LEN=%0d must be >= 1", FILT_LEN);
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    is_uart_sync_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .RST_VAL     (RST_VAL)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .in_i   (in_i[g]),
      .out_o  (out_o[g]),
      .rise_o (rise_o[g]),
      .fall_o (fall_o[g])
    );
  end

endmodule
